wb_timeout: RTL

// Wishbone bus watchdog placed directly downstream of a wishbone register slice, between it and a slave.

---
 rtl/wb_timeout.sv | 129 ++++++++++++
 1 files changed

// File: rtl/wb_timeout.sv
// Wishbone watchdog: forwards master requests to a slave and aborts any cycle
// left unanswered for TIMEOUT strobe cycles, ending the master with ERR.
module wb_timeout #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 256,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic                    wbm_stb_i,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic                    wbm_rty_o,
  input  logic                    wbm_cyc_i,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic                    wbs_cyc_o,
  input  logic                    clear_i,
  output logic                    timeout_o,
  output logic                    timeout_flag_o,
  output logic [CNT_WIDTH-1:0]    timeout_count_o
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0]        TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ABORT} state_t;

  state_t               r_state, w_state_nxt;
  logic [TW-1:0]        r_timer, w_timer_nxt;
  logic                 r_flag;
  logic [CNT_WIDTH-1:0] r_count;

  logic w_req, w_rsp, w_abort, w_pass;

  assign w_req   = wbm_cyc_i & wbm_stb_i;
  assign w_rsp   = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign w_abort = (r_state == S_ABORT);
  // rst_n gates the outputs directly so they drop without waiting for a clock
  assign w_pass  = rst_n & ~w_abort;

  assign wbs_adr_o = wbm_adr_i;
  assign wbs_dat_o = wbm_dat_i;
  assign wbs_sel_o = wbm_sel_i;
  assign wbs_we_o  = wbm_we_i  & w_pass;
  assign wbs_stb_o = wbm_stb_i & w_pass;
  assign wbs_cyc_o = wbm_cyc_i & w_pass;

  assign wbm_ack_o = wbs_ack_i & w_req & w_pass;
  assign wbm_rty_o = wbs_rty_i & w_req & w_pass;
  assign wbm_err_o = rst_n & (w_abort | (wbs_err_i & w_req));
  assign wbm_dat_o = w_pass ? wbs_dat_i : '0;

  assign timeout_o       = rst_n & w_abort;
  assign timeout_flag_o  = r_flag;
  assign timeout_count_o = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      S_IDLE: begin
        if (w_req && !w_rsp) begin
          w_state_nxt = S_WAIT;
          w_timer_nxt = TW'(1);
        end
      end
      S_WAIT: begin
        if (w_rsp || !w_req) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == TIMER_LAST) begin
          w_state_nxt = S_ABORT;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_ABORT: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  // A timeout in the same cycle as clear_i wins: the event is recorded afresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag  <= 1'b0;
      r_count <= '0;
    end else if (w_abort) begin
      r_flag  <= 1'b1;
      if (clear_i)               r_count <= CNT_WIDTH'(1);
      else if (r_count != CNT_MAX) r_count <= r_count + CNT_WIDTH'(1);
    end else if (clear_i) begin
      r_flag  <= 1'b0;
      r_count <= '0;
    end
  end

endmodule
